// File: rtl/cmp_addsub_pipe_pkg.sv
// Shared types and lane arithmetic for the pipelined compare/add-sub unit.
// lane_op works on a fixed maximum width; callers pass their real lane width as nx.
package cmp_addsub_pipe_pkg;

  localparam int unsigned LANE_MAXW = 64;
  localparam int unsigned LANE_IDXW = 7;

  typedef struct packed {
    logic                 ovf;
    logic [LANE_MAXW-1:0] res;
  } lane_res_t;

  function automatic lane_res_t lane_op(input logic [LANE_MAXW-1:0] a,
                                        input logic [LANE_MAXW-1:0] b,
                                        input logic                 gt,
                                        input logic                 sat,
                                        input int unsigned          nx);
    logic [LANE_MAXW-1:0] mask;
    logic [LANE_MAXW:0]   wide;
    lane_res_t            r;
    mask = (nx >= LANE_MAXW) ? '1 : ((LANE_MAXW'(1) << nx) - LANE_MAXW'(1));
    if (gt) wide = {1'b0, a} + {1'b0, b};
    else    wide = {1'b0, a} - {1'b0, b};
    // Carry out of an nx-bit lane sits at bit nx; a borrow is simply a < b.
    r.ovf = gt ? wide[nx[LANE_IDXW-1:0]] : (a < b);
    r.res = wide[LANE_MAXW-1:0] & mask;
    if (sat && r.ovf) r.res = gt ? mask : '0;
    return r;
  endfunction

endpackage

// File: rtl/cmp_addsub_lane.sv
// One lane: add when gt, else subtract; wrap or saturate, plus carry/borrow flag.
module cmp_addsub_lane
  import cmp_addsub_pipe_pkg::*;
#(
  parameter int unsigned NX  = 8,
  parameter int unsigned SAT = 0
) (
  input  logic [NX-1:0] a_i,
  input  logic [NX-1:0] b_i,
  input  logic          gt_i,
  output logic [NX-1:0] res_o,
  output logic          ovf_o
);

  lane_res_t r;
  logic      lane_unused;

  always_comb r = lane_op(LANE_MAXW'(a_i), LANE_MAXW'(b_i), gt_i, (SAT != 0), NX);

  assign res_o       = r.res[NX-1:0];
  assign ovf_o       = r.ovf;
  assign lane_unused = ^r.res;

endmodule

// File: rtl/cmp_addsub_pipe.sv
// Multi-lane compare/add-sub with a 2-stage valid/ready pipeline and transfer counter.
// Handshake: a beat moves on a rising edge when valid & ready; each stage loads when empty or drained.
module cmp_addsub_pipe
  import cmp_addsub_pipe_pkg::*;
#(
  parameter int unsigned NX   = 8,
  parameter int unsigned NCH  = 4,
  parameter int unsigned SAT  = 0,
  parameter int unsigned NCNT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [NCH*NX-1:0] A,
  input  logic [NCH*NX-1:0] B,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [NCH*NX-1:0] XOUT,
  output logic [NCH-1:0]    GT,
  output logic [NCH-1:0]    OVF,
  output logic [NCNT-1:0]   COUNT
);

  typedef struct packed {
    logic              valid;
    logic [NCH*NX-1:0] a;
    logic [NCH*NX-1:0] b;
    logic [NCH-1:0]    gt;
  } stage_t;

  stage_t            s1_q, s1_d;
  logic              s2_valid_q, s2_valid_d;
  logic [NCH*NX-1:0] xout_q, xout_d;
  logic [NCH-1:0]    gt_q, gt_d;
  logic [NCH-1:0]    ovf_q, ovf_d;
  logic [NCNT-1:0]   count_q, count_d;

  logic              s1_en, s2_en;
  logic [NCH-1:0]    in_gt;
  logic [NCH*NX-1:0] lane_res;
  logic [NCH-1:0]    lane_ovf;

  assign s2_en = !s2_valid_q || OUT_READY;
  assign s1_en = !s1_q.valid || s2_en;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    assign in_gt[g] = A[g*NX +: NX] > B[g*NX +: NX];

    cmp_addsub_lane #(
      .NX (NX),
      .SAT(SAT)
    ) u_lane (
      .a_i  (s1_q.a[g*NX +: NX]),
      .b_i  (s1_q.b[g*NX +: NX]),
      .gt_i (s1_q.gt[g]),
      .res_o(lane_res[g*NX +: NX]),
      .ovf_o(lane_ovf[g])
    );
  end

  // Operand registers only move on an accepted beat, so bubbles do not toggle them.
  always_comb begin
    s1_d = s1_q;
    if (s1_en) begin
      s1_d.valid = IN_VALID;
      if (IN_VALID) begin
        s1_d.a  = A;
        s1_d.b  = B;
        s1_d.gt = in_gt;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    xout_d     = xout_q;
    gt_d       = gt_q;
    ovf_d      = ovf_q;
    if (s2_en) begin
      s2_valid_d = s1_q.valid;
      if (s1_q.valid) begin
        xout_d = lane_res;
        gt_d   = s1_q.gt;
        ovf_d  = lane_ovf;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (s2_valid_q && OUT_READY) count_d = count_q + NCNT'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      xout_q     <= '0;
      gt_q       <= '0;
      ovf_q      <= '0;
      count_q    <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      xout_q     <= xout_d;
      gt_q       <= gt_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
    end
  end

  assign IN_READY  = s1_en;
  assign OUT_VALID = s2_valid_q;
  assign XOUT      = xout_q;
  assign GT        = gt_q;
  assign OVF       = ovf_q;
  assign COUNT     = count_q;

endmodule

// File: tb/tb_cmp_addsub_pipe.sv
// Bench for cmp_addsub_pipe: a wrapping 16-bit-counter instance and a saturating
// 4-bit-counter instance share one stimulus stream and one expected queue.
module tb_cmp_addsub_pipe;

  localparam int NX   = 8;
  localparam int NCH  = 4;
  localparam int W    = NX * NCH;
  localparam int BW   = W + 2 * NCH;
  localparam int EW   = 2 * BW;
  localparam int MAXV = (1 << NX) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           in_valid, out_ready;
  logic [W-1:0]   a, b;
  logic           in_ready0, out_valid0, in_ready1, out_valid1;
  logic [W-1:0]   xout0, xout1;
  logic [NCH-1:0] gt0, ovf0, gt1, ovf1;
  logic [15:0]    count0;
  logic [3:0]     count1;

  cmp_addsub_pipe #(.NX(NX), .NCH(NCH), .SAT(0), .NCNT(16)) dut_wrap (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready0),
    .A(a), .B(b), .OUT_VALID(out_valid0), .OUT_READY(out_ready),
    .XOUT(xout0), .GT(gt0), .OVF(ovf0), .COUNT(count0)
  );

  cmp_addsub_pipe #(.NX(NX), .NCH(NCH), .SAT(1), .NCNT(4)) dut_sat (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready1),
    .A(a), .B(b), .OUT_VALID(out_valid1), .OUT_READY(out_ready),
    .XOUT(xout1), .GT(gt1), .OVF(ovf1), .COUNT(count1)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_in     = 0;
  int n_out    = 0;
  logic last_in_ready;

  task automatic check_eq(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] ref_beat(input logic [W-1:0] av, input logic [W-1:0] bv,
                                             input bit sat);
    logic [W-1:0]   x;
    logic [NCH-1:0] g, o;
    int ai, bi, s;
    for (int i = 0; i < NCH; i++) begin
      ai = int'(av[i*NX +: NX]);
      bi = int'(bv[i*NX +: NX]);
      if (ai > bi) begin
        g[i] = 1'b1;
        s    = ai + bi;
        o[i] = (s > MAXV);
        if (o[i]) s = sat ? MAXV : s - (MAXV + 1);
      end else begin
        g[i] = 1'b0;
        s    = ai - bi;
        o[i] = (s < 0);
        if (o[i]) s = sat ? 0 : s + (MAXV + 1);
      end
      x[i*NX +: NX] = s[NX-1:0];
    end
    return {x, g, o};
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < NCH; i++) begin
      case ($urandom_range(0, 7))
        0:       w[i*NX +: NX] = '0;
        1:       w[i*NX +: NX] = '1;
        default: w[i*NX +: NX] = NX'($urandom_range(0, MAXV));
      endcase
    end
    return w;
  endfunction

  // ---------------- driver + monitor ----------------
  // Inputs change just after a rising edge; both transfers are observed on the falling edge.
  task automatic step(input logic iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ordy);
    logic [EW-1:0] exp;
    in_valid  = iv;
    a         = av;
    b         = bv;
    out_ready = ordy;
    @(negedge clk);
    last_in_ready = in_ready0;
    if (in_valid && in_ready0) begin
      exp_q.push_back({ref_beat(a, b, 1'b0), ref_beat(a, b, 1'b1)});
      n_in++;
    end
    if (out_valid0 && out_ready) begin
      check_eq("out_has_expected", EW'(exp_q.size() != 0), EW'(1));
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check_eq("beat", {xout0, gt0, ovf0, xout1, gt1, ovf1}, exp);
      end
      n_out++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || out_valid0) && k < 50) begin
      step(1'b0, '0, '0, 1'b1);
      k++;
    end
    check_eq("drain_done", EW'(exp_q.size()), EW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [W-1:0] va, vb;

    // ---------------- reset ----------------
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", EW'({out_valid0, out_valid1}), EW'(0));
    check_eq("rst_count",     EW'({count0, count1}), EW'(0));
    check_eq("rst_data",      EW'({xout0, gt0, ovf0, xout1, gt1, ovf1}), EW'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check_eq("rst_in_ready", EW'(in_ready0), EW'(1));

    // ---------------- directed, latency and literal results ----------------
    va = {8'd200, 8'd7, 8'd3, 8'd10};
    vb = {8'd100, 8'd7, 8'd10, 8'd3};
    step(1'b1, va, vb, 1'b1);
    check_eq("lat_cycle1", EW'(out_valid0), EW'(0));
    step(1'b0, '0, '0, 1'b1);
    check_eq("lat_cycle2", EW'(out_valid0), EW'(1));
    check_eq("wrap_xout", EW'(xout0), EW'(32'h2C00F90D));
    check_eq("wrap_gt",   EW'(gt0),   EW'(4'b1001));
    check_eq("wrap_ovf",  EW'(ovf0),  EW'(4'b1010));
    check_eq("sat_xout",  EW'(xout1), EW'(32'hFF00000D));
    drain();

    va = {8'd0, 8'd255, 8'd100, 8'd5};
    vb = {8'd255, 8'd255, 8'd50, 8'd9};
    step(1'b1, va, vb, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    check_eq("wrap_xout2", EW'(xout0), EW'(32'h010096FC));
    check_eq("wrap_gt2",   EW'(gt0),   EW'(4'b0010));
    check_eq("wrap_ovf2",  EW'(ovf0),  EW'(4'b1001));
    check_eq("sat_xout2",  EW'(xout1), EW'(32'h00009600));
    check_eq("sat_ovf2",   EW'(ovf1),  EW'(4'b1001));
    drain();

    // ---------------- streaming ----------------
    base = n_out;
    for (int i = 0; i < 100; i++) step(1'b1, rand_word(), rand_word(), 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    check_eq("stream_outputs", EW'(n_out - base), EW'(100));
    check_eq("stream_count0",  EW'(count0), EW'(n_out[15:0]));
    check_eq("stream_count1",  EW'(count1), EW'(n_out[3:0]));
    drain();

    // ---------------- back-pressure ----------------
    base = n_in;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, rand_word(), rand_word(), 1'b0);
      check_eq($sformatf("bp_in_ready%0d", k), EW'(last_in_ready), EW'(k < 2));
      if (k >= 2 && exp_q.size() != 0)
        check_eq($sformatf("bp_hold%0d", k), {xout0, gt0, ovf0, xout1, gt1, ovf1}, exp_q[0]);
    end
    check_eq("bp_accepted", EW'(n_in - base), EW'(2));
    step(1'b1, rand_word(), rand_word(), 1'b1);
    check_eq("bp_full_accept", EW'(last_in_ready), EW'(1));
    drain();

    // ---------------- reset mid-stream ----------------
    step(1'b1, rand_word(), rand_word(), 1'b0);
    step(1'b1, rand_word(), rand_word(), 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", EW'({out_valid0, out_valid1}), EW'(0));
    check_eq("midrst_count",     EW'({count0, count1}), EW'(0));
    exp_q.delete();
    n_out = 0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    check_eq("midrst_no_replay", EW'(n_out), EW'(0));

    // ---------------- counter wrap ----------------
    for (int i = 0; i < 17; i++) step(1'b1, rand_word(), rand_word(), 1'b1);
    drain();
    check_eq("wrap_count1", EW'(count1), EW'(4'd1));
    check_eq("wrap_count0", EW'(count0), EW'(16'd17));

    // ---------------- random handshake ----------------
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), rand_word(), rand_word(), ($urandom_range(0, 3) != 0));
    drain();
    check_eq("rand_count0", EW'(count0), EW'(n_out[15:0]));
    check_eq("rand_count1", EW'(count1), EW'(n_out[3:0]));
    check_eq("rand_in_out", EW'(n_out), EW'(n_in - base - 2 - 1 - 2));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
